// File: rtl/id_scroller.sv
`default_nettype none
// ============================================================================
// Module   : id_scroller
// Purpose  : Scrolls a 4-digit window across an 8-digit BCD identifier for a
//            multiplexed 4-digit display.  A free-running scan divider makes
//            the display strobe; every SCROLL_SCANS strobes taken while run
//            is high, the window start index steps left or right (mod 8).
// Ports    : clk    - single clock, rising edge
//            rst    - synchronous active-high reset
//            run    - 1 = scrolling enabled, 0 = window frozen
//            dir    - 0 = step offset up, 1 = step offset down
//            en     - one-cycle scan strobe for the downstream display
//            d3..d0 - registered BCD window, d3 leftmost
//            offset - current window start index 0..7
// Revision : 1.0  initial release
// ============================================================================
module id_scroller #(
   parameter logic [31:0] ID           = 32'h3190_1234,
   parameter int          SCAN_DIV     = 4,
   parameter int          SCROLL_SCANS = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       dir,
   output logic       en,
   output logic [3:0] d3,
   output logic [3:0] d2,
   output logic [3:0] d1,
   output logic [3:0] d0,
   output logic [2:0] offset
);

   // Terminal counts; both fit in 16 bits over the legal parameter range.
   localparam logic [15:0] SCAN_LAST   = 16'(SCAN_DIV - 1);
   localparam logic [15:0] SCROLL_LAST = 16'(SCROLL_SCANS - 1);

   // ------------------------------------------------------------------------
   // Identifier split into digits; digit 0 is the most significant nibble.
   // ------------------------------------------------------------------------
   logic [3:0] id_digit [8];

   generate
      for (genvar i = 0; i < 8; i++) begin : g_id_digits
         assign id_digit[i] = ID[31 - 4*i -: 4];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [15:0] scan_cnt_q,   scan_cnt_d;
   logic [15:0] scroll_cnt_q, scroll_cnt_d;
   logic [2:0]  offset_q,     offset_d;
   logic [3:0]  d3_q, d3_d;
   logic [3:0]  d2_q, d2_d;
   logic [3:0]  d1_q, d1_d;
   logic [3:0]  d0_q, d0_d;

   logic scan_wrap;
   logic scroll_adv;
   logic step;

   // The strobe is a pure decode of the scan counter so it never depends on
   // run or dir, and it is low in the first cycle after reset because the
   // counter restarts at 0 and SCAN_DIV is at least 2.
   assign scan_wrap = (scan_cnt_q == SCAN_LAST);
   assign en        = scan_wrap;

   always_comb begin
      scan_cnt_d   = scan_wrap ? 16'd0 : scan_cnt_q + 16'd1;

      scroll_adv   = scan_wrap && run;
      step         = scroll_adv && (scroll_cnt_q == SCROLL_LAST);

      scroll_cnt_d = scroll_cnt_q;
      if (scroll_adv) begin
         scroll_cnt_d = step ? 16'd0 : scroll_cnt_q + 16'd1;
      end

      // dir is only looked at here, so changing it mid-count affects only
      // the next step; the 3-bit arithmetic gives the mod-8 wrap for free.
      offset_d = offset_q;
      if (step) begin
         offset_d = dir ? offset_q - 3'd1 : offset_q + 3'd1;
      end

      // The window is reloaded from the new offset on the same edge, so the
      // digits and offset become visible together.
      d3_d = d3_q;
      d2_d = d2_q;
      d1_d = d1_q;
      d0_d = d0_q;
      if (step) begin
         d3_d = id_digit[offset_d];
         d2_d = id_digit[offset_d + 3'd1];
         d1_d = id_digit[offset_d + 3'd2];
         d0_d = id_digit[offset_d + 3'd3];
      end
   end

   // Reset wins over everything, including a step that would fall on the
   // same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_q   <= 16'd0;
         scroll_cnt_q <= 16'd0;
         offset_q     <= 3'd0;
         d3_q         <= id_digit[0];
         d2_q         <= id_digit[1];
         d1_q         <= id_digit[2];
         d0_q         <= id_digit[3];
      end else begin
         scan_cnt_q   <= scan_cnt_d;
         scroll_cnt_q <= scroll_cnt_d;
         offset_q     <= offset_d;
         d3_q         <= d3_d;
         d2_q         <= d2_d;
         d1_q         <= d1_d;
         d0_q         <= d0_d;
      end
   end

   assign d3     = d3_q;
   assign d2     = d2_q;
   assign d1     = d1_q;
   assign d0     = d0_q;
   assign offset = offset_q;

endmodule
`default_nettype wire

// File: tb/tb_id_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_scroller
// Purpose  : Self-checking bench for id_scroller.  A reference model tracks
//            cycles since reset, the number of strobes taken while running
//            and the window offset, and derives the expected window by
//            slicing the identifier arithmetically.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_scroller;

   localparam logic [31:0] ID_VAL = 32'h3190_1234;
   localparam int SCAN_DIV     = 4;
   localparam int SCROLL_SCANS = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b1;
   logic       dir = 1'b0;
   logic       en;
   logic [3:0] d3, d2, d1, d0;
   logic [2:0] offset;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_cyc    = 0;   // cycles since the last reset edge
   int m_active = 0;   // strobes taken with run high since the last step
   int m_off    = 0;

   id_scroller #(
      .ID           (ID_VAL),
      .SCAN_DIV     (SCAN_DIV),
      .SCROLL_SCANS (SCROLL_SCANS)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .dir    (dir),
      .en     (en),
      .d3     (d3),
      .d2     (d2),
      .d1     (d1),
      .d0     (d0),
      .offset (offset)
   );

   always #5 clk = ~clk;

   function automatic logic exp_en();
      return (m_cyc % SCAN_DIV) == (SCAN_DIV - 1);
   endfunction

   function automatic logic [15:0] exp_win(int off);
      logic [15:0] w;
      logic [31:0] sh;
      w = 16'h0;
      for (int k = 0; k < 4; k++) begin
         sh = ID_VAL >> (28 - 4 * ((off + k) % 8));
         w  = {w[11:0], sh[3:0]};
      end
      return w;
   endfunction

   function automatic logic [22:0] exp_all();
      return {exp_en(), 3'(m_off), exp_win(m_off), 1'b0} >> 1;
   endfunction

   // Advance the model using the inputs present at this edge, then move past
   // the edge so outputs can be sampled.
   task automatic tick();
      if (rst) begin
         m_cyc    = 0;
         m_active = 0;
         m_off    = 0;
      end else begin
         if (exp_en() && run) begin
            m_active++;
            if (m_active == SCROLL_SCANS) begin
               m_active = 0;
               m_off    = dir ? (m_off + 7) % 8 : (m_off + 1) % 8;
            end
         end
         m_cyc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      run = 1'b1;
      dir = 1'b0;
      do_reset();
      total++;
      if ({en, offset, d3, d2, d1, d0} !== {1'b0, 3'd0, 16'h3190}) begin
         bad++;
         $display("FAIL reset_state got en=%b off=%0d win=%h exp en=0 off=0 win=3190",
                  en, offset, {d3, d2, d1, d0});
      end
   endtask

   task automatic test_first_step();
      run = 1'b1;
      dir = 1'b0;
      do_reset();
      for (int c = 0; c < 48; c++) begin
         total++;
         if ({en, offset, d3, d2, d1, d0} !== {(c % 4) == 3, 3'd0, 16'h3190}) begin
            bad++;
            $display("FAIL first_step_cadence c=%0d got en=%b off=%0d win=%h exp en=%b off=0 win=3190",
                     c, en, offset, {d3, d2, d1, d0}, (c % 4) == 3);
         end
         tick();
      end
      total++;
      if ({offset, d3, d2, d1, d0} !== {3'd1, 16'h1901}) begin
         bad++;
         $display("FAIL first_step_window got off=%0d win=%h exp off=1 win=1901",
                  offset, {d3, d2, d1, d0});
      end
   endtask

   // Continues from test_first_step (cycle 48).
   task automatic test_left_wrap();
      for (int c = 48; c < 384; c++) begin
         if (c == 240) begin
            total++;
            if ({offset, d3, d2, d1, d0} !== {3'd5, 16'h2343}) begin
               bad++;
               $display("FAIL left_wrap_5 got off=%0d win=%h exp off=5 win=2343",
                        offset, {d3, d2, d1, d0});
            end
         end
         total++;
         if ({en, offset, d3, d2, d1, d0} !== exp_all()[20:0]) begin
            bad++;
            $display("FAIL left_wrap_model c=%0d got en=%b off=%0d win=%h exp %h",
                     c, en, offset, {d3, d2, d1, d0}, exp_all()[20:0]);
         end
         tick();
      end
      total++;
      if ({offset, d3, d2, d1, d0} !== {3'd0, 16'h3190}) begin
         bad++;
         $display("FAIL left_wrap_8 got off=%0d win=%h exp off=0 win=3190",
                  offset, {d3, d2, d1, d0});
      end
   endtask

   task automatic test_right_step();
      run = 1'b1;
      dir = 1'b1;
      do_reset();
      for (int c = 0; c < 48; c++) tick();
      total++;
      if ({offset, d3, d2, d1, d0} !== {3'd7, 16'h4319}) begin
         bad++;
         $display("FAIL right_step got off=%0d win=%h exp off=7 win=4319",
                  offset, {d3, d2, d1, d0});
      end
      dir = 1'b0;
   endtask

   // dir flips well before the step edge; only its value at the step counts.
   task automatic test_dir_sample();
      run = 1'b1;
      dir = 1'b1;
      do_reset();
      for (int c = 0; c < 48; c++) begin
         if (c == 40) dir = 1'b0;
         tick();
      end
      total++;
      if ({offset, d3, d2, d1, d0} !== {3'd1, 16'h1901}) begin
         bad++;
         $display("FAIL dir_sample got off=%0d win=%h exp off=1 win=1901",
                  offset, {d3, d2, d1, d0});
      end
   endtask

   task automatic test_freeze();
      int pulses;
      run = 1'b1;
      dir = 1'b0;
      do_reset();
      for (int c = 0; c < 24; c++) tick();
      run    = 1'b0;
      pulses = 0;
      for (int c = 24; c < 104; c++) begin
         if (en === 1'b1) pulses++;
         total++;
         if ({en, offset, d3, d2, d1, d0} !== {(c % 4) == 3, 3'd0, 16'h3190}) begin
            bad++;
            $display("FAIL freeze_hold c=%0d got en=%b off=%0d win=%h exp en=%b off=0 win=3190",
                     c, en, offset, {d3, d2, d1, d0}, (c % 4) == 3);
         end
         tick();
      end
      total++;
      if (pulses !== 20) begin
         bad++;
         $display("FAIL freeze_pulses got=%0d exp=20", pulses);
      end
      run = 1'b1;
      for (int c = 104; c < 127; c++) tick();
      total++;
      if (offset !== 3'd0) begin
         bad++;
         $display("FAIL freeze_resume_early got off=%0d exp off=0", offset);
      end
      tick();
      total++;
      if ({offset, d3, d2, d1, d0} !== {3'd1, 16'h1901}) begin
         bad++;
         $display("FAIL freeze_resume_step got off=%0d win=%h exp off=1 win=1901",
                  offset, {d3, d2, d1, d0});
      end
   endtask

   task automatic test_reset_on_step();
      run = 1'b1;
      dir = 1'b0;
      do_reset();
      for (int c = 0; c < 47; c++) tick();
      total++;
      if (en !== 1'b1) begin
         bad++;
         $display("FAIL rst_step_pending got en=%b exp en=1", en);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({en, offset, d3, d2, d1, d0} !== {1'b0, 3'd0, 16'h3190}) begin
         bad++;
         $display("FAIL rst_step_discard got en=%b off=%0d win=%h exp en=0 off=0 win=3190",
                  en, offset, {d3, d2, d1, d0});
      end
      for (int c = 0; c < 48; c++) begin
         total++;
         if ({en, offset} !== {(c % 4) == 3, 3'd0}) begin
            bad++;
            $display("FAIL rst_step_cadence c=%0d got en=%b off=%0d exp en=%b off=0",
                     c, en, offset, (c % 4) == 3);
         end
         tick();
      end
      total++;
      if ({offset, d3, d2, d1, d0} !== {3'd1, 16'h1901}) begin
         bad++;
         $display("FAIL rst_step_after got off=%0d win=%h exp off=1 win=1901",
                  offset, {d3, d2, d1, d0});
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 99) < 4) run = ~run;
         if ($urandom_range(0, 99) < 3) dir = ~dir;
         tick();
         total++;
         if ({en, offset, d3, d2, d1, d0} !== exp_all()[20:0]) begin
            bad++;
            $display("FAIL random_model c=%0d got en=%b off=%0d win=%h exp %h",
                     c, en, offset, {d3, d2, d1, d0}, exp_all()[20:0]);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_step();
      test_left_wrap();
      test_right_step();
      test_dir_sample();
      test_freeze();
      test_reset_on_step();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
